// File: rtl/machine_timer.sv
// machine_timer: memory-mapped 32-bit timer with prescaler, compare match,
// auto-reload and a level interrupt request. Single-cycle registered bus ack.
module machine_timer (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_i,
    input  logic        we_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] data_i,
    output logic [31:0] data_o,
    output logic        ack_o,
    output logic        int_sig_o
);

    localparam int unsigned RegBus = 32;

    localparam logic [3:0] OFF_CTRL     = 4'h0;
    localparam logic [3:0] OFF_COUNT    = 4'h4;
    localparam logic [3:0] OFF_COMPARE  = 4'h8;
    localparam logic [3:0] OFF_PRESCALE = 4'hC;

    // Architectural state
    logic              en_q,  en_d;
    logic              ie_q,  ie_d;
    logic              ip_q,  ip_d;
    logic              ar_q,  ar_d;
    logic [RegBus-1:0] count_q,    count_d;
    logic [RegBus-1:0] compare_q,  compare_d;
    logic [RegBus-1:0] prescale_q, prescale_d;
    logic [RegBus-1:0] pcnt_q,     pcnt_d;

    // Bus response and interrupt output flops
    logic [RegBus-1:0] rdata_q, rdata_d;
    logic              ack_q,   ack_d;
    logic              int_q,   int_d;

    // Decoded accesses and tick qualifiers
    logic              wr_c;
    logic              wr_ctrl_c;
    logic              wr_count_c;
    logic              wr_compare_c;
    logic              wr_prescale_c;
    logic              tick_c;
    logic              match_c;
    logic [RegBus-1:0] rmux_c;

    // Upper address bits are decoded by the bus fabric, not here
    logic              unused_addr_c;
    assign unused_addr_c = ^addr_i[31:4];

    // Write decode; offsets with addr_i[1:0] != 0 fall through as unmapped
    always_comb begin
        wr_c          = req_i & we_i;
        wr_ctrl_c     = wr_c & (addr_i[3:0] == OFF_CTRL);
        wr_count_c    = wr_c & (addr_i[3:0] == OFF_COUNT);
        wr_compare_c  = wr_c & (addr_i[3:0] == OFF_COMPARE);
        wr_prescale_c = wr_c & (addr_i[3:0] == OFF_PRESCALE);
    end

    // Read mux over current register values; unmapped offsets read zero
    always_comb begin
        rmux_c = '0;
        case (addr_i[3:0])
            OFF_CTRL:     rmux_c = {28'd0, ar_q, ip_q, ie_q, en_q};
            OFF_COUNT:    rmux_c = count_q;
            OFF_COMPARE:  rmux_c = compare_q;
            OFF_PRESCALE: rmux_c = prescale_q;
            default:      rmux_c = '0;
        endcase
    end

    // Next-state logic for control bits, counters, bus response and interrupt
    always_comb begin
        en_d       = en_q;
        ie_d       = ie_q;
        ar_d       = ar_q;
        ip_d       = ip_q;
        count_d    = count_q;
        compare_d  = compare_q;
        prescale_d = prescale_q;
        pcnt_d     = pcnt_q;
        rdata_d    = '0;
        ack_d      = req_i;
        int_d      = 1'b0;

        if (wr_ctrl_c) begin
            en_d = data_i[0];
            ie_d = data_i[1];
            ar_d = data_i[3];
        end

        // A CTRL write that clears EN also kills a tick due this cycle
        tick_c  = en_q & en_d & (pcnt_q == prescale_q);
        match_c = (count_q == compare_q);

        if (!en_d || wr_count_c || wr_prescale_c) begin
            pcnt_d = '0;
        end else if (tick_c) begin
            pcnt_d = '0;
        end else if (en_q) begin
            pcnt_d = pcnt_q + RegBus'(1);
        end

        // Bus write to COUNT has priority over the tick update
        if (wr_count_c) begin
            count_d = data_i;
        end else if (tick_c) begin
            if (match_c && ar_q) begin
                count_d = '0;
            end else begin
                count_d = count_q + RegBus'(1);
            end
        end

        if (wr_compare_c) begin
            compare_d = data_i;
        end
        if (wr_prescale_c) begin
            prescale_d = data_i;
        end

        // Hardware set wins over software write-one-to-clear
        if (wr_ctrl_c && data_i[2]) begin
            ip_d = 1'b0;
        end
        if (tick_c && match_c) begin
            ip_d = 1'b1;
        end

        if (req_i && !we_i) begin
            rdata_d = rmux_c;
        end

        // Registered from next-state so the request tracks IP/IE with no lag
        int_d = ip_d & ie_d;
    end

    // State registers with asynchronous active-low reset
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            en_q       <= 1'b0;
            ie_q       <= 1'b0;
            ip_q       <= 1'b0;
            ar_q       <= 1'b0;
            count_q    <= '0;
            compare_q  <= '0;
            prescale_q <= '0;
            pcnt_q     <= '0;
            rdata_q    <= '0;
            ack_q      <= 1'b0;
            int_q      <= 1'b0;
        end else begin
            en_q       <= en_d;
            ie_q       <= ie_d;
            ip_q       <= ip_d;
            ar_q       <= ar_d;
            count_q    <= count_d;
            compare_q  <= compare_d;
            prescale_q <= prescale_d;
            pcnt_q     <= pcnt_d;
            rdata_q    <= rdata_d;
            ack_q      <= ack_d;
            int_q      <= int_d;
        end
    end

    assign data_o    = rdata_q;
    assign ack_o     = ack_q;
    assign int_sig_o = int_q;

endmodule

// File: tb/tb_machine_timer.sv
// tb_machine_timer: directed vector table plus hand-built multi-cycle
// sequences for prescaler, collisions, wrap/masking and async reset.
module tb_machine_timer;

    logic        clk;
    logic        rst;
    logic        req_i;
    logic        we_i;
    logic [31:0] addr_i;
    logic [31:0] data_i;
    logic [31:0] data_o;
    logic        ack_o;
    logic        int_sig_o;

    int errors;
    int checks;

    machine_timer dut (
        .clk       (clk),
        .rst       (rst),
        .req_i     (req_i),
        .we_i      (we_i),
        .addr_i    (addr_i),
        .data_i    (data_i),
        .data_o    (data_o),
        .ack_o     (ack_o),
        .int_sig_o (int_sig_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_rd;
        logic        exp_int;
    } vec_t;

    localparam int NVEC = 25;
    vec_t vecs [NVEC];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // One bus access issued at a negedge; returns at the negedge of the ack cycle
    task automatic access(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                          output logic [31:0] rd);
        req_i  = 1'b1;
        we_i   = we;
        addr_i = addr;
        data_i = wdata;
        @(posedge clk);
        @(negedge clk);
        check("ack", 32'(ack_o), 32'd1);
        rd     = data_o;
        req_i  = 1'b0;
        we_i   = 1'b0;
        addr_i = '0;
        data_i = '0;
    endtask

    task automatic wr(input logic [31:0] addr, input logic [31:0] wdata);
        logic [31:0] rd;
        access(1'b1, addr, wdata, rd);
        check("wr_data_o", rd, 32'd0);
    endtask

    task automatic rd_chk(input string name, input logic [31:0] addr, input logic [31:0] exp);
        logic [31:0] rd;
        access(1'b0, addr, 32'd0, rd);
        check(name, rd, exp);
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    function automatic vec_t mk(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                                input logic [31:0] exp_rd, input logic exp_int);
        vec_t v;
        v.we = we; v.addr = addr; v.wdata = wdata; v.exp_rd = exp_rd; v.exp_int = exp_int;
        return v;
    endfunction

    initial begin
        logic [31:0] rd;
        errors = 0;
        checks = 0;
        rst    = 1'b0;
        req_i  = 1'b0;
        we_i   = 1'b0;
        addr_i = '0;
        data_i = '0;

        // Reset reads, basic match with P=0/COMPARE=5, unmapped and aliased offsets
        vecs[0]  = mk(1'b0, 32'h0, 32'h0, 32'h0, 1'b0);
        vecs[1]  = mk(1'b0, 32'h4, 32'h0, 32'h0, 1'b0);
        vecs[2]  = mk(1'b0, 32'h8, 32'h0, 32'h0, 1'b0);
        vecs[3]  = mk(1'b0, 32'hC, 32'h0, 32'h0, 1'b0);
        vecs[4]  = mk(1'b1, 32'hC, 32'h0, 32'h0, 1'b0);
        vecs[5]  = mk(1'b1, 32'h8, 32'h5, 32'h0, 1'b0);
        vecs[6]  = mk(1'b1, 32'h0, 32'h3, 32'h0, 1'b0);
        for (int i = 0; i < 7; i++) begin
            vecs[7+i] = mk(1'b0, 32'h4, 32'h0, 32'(i), (i >= 5));
        end
        vecs[14] = mk(1'b0, 32'h0, 32'h0, 32'h7, 1'b1);
        vecs[15] = mk(1'b1, 32'h0, 32'h4, 32'h0, 1'b0);
        vecs[16] = mk(1'b0, 32'h0, 32'h0, 32'h0, 1'b0);
        vecs[17] = mk(1'b0, 32'h4, 32'h0, 32'h8, 1'b0);
        vecs[18] = mk(1'b1, 32'h1, 32'hFFFF_FFFF, 32'h0, 1'b0);
        vecs[19] = mk(1'b0, 32'h2, 32'h0, 32'h0, 1'b0);
        vecs[20] = mk(1'b0, 32'h0, 32'h0, 32'h0, 1'b0);
        vecs[21] = mk(1'b0, 32'h4, 32'h0, 32'h8, 1'b0);
        vecs[22] = mk(1'b1, 32'h8, 32'hA5, 32'h0, 1'b0);
        vecs[23] = mk(1'b0, 32'h108, 32'h0, 32'hA5, 1'b0);
        vecs[24] = mk(1'b0, 32'hFFFF_FFF4, 32'h0, 32'h8, 1'b0);

        #1;
        check("rst_int", 32'(int_sig_o), 32'd0);
        check("rst_ack", 32'(ack_o), 32'd0);
        check("rst_data", data_o, 32'd0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);

        for (int i = 0; i < NVEC; i++) begin
            access(vecs[i].we, vecs[i].addr, vecs[i].wdata, rd);
            check($sformatf("vec%0d_rd", i), rd, vecs[i].exp_rd);
            check($sformatf("vec%0d_int", i), 32'(int_sig_o), 32'(vecs[i].exp_int));
        end
        @(negedge clk);
        check("ack_one_cycle", 32'(ack_o), 32'd0);

        // Prescaler with auto-reload: P=3, COMPARE=2
        wr(32'hC, 32'd3);
        wr(32'h8, 32'd2);
        wr(32'h4, 32'd0);
        wr(32'h0, 32'hB);
        for (int t = 0; t < 14; t++) begin
            rd_chk($sformatf("presc_cnt_t%0d", t), 32'h4, (t < 12) ? 32'(t / 4) : 32'd0);
            check($sformatf("presc_int_t%0d", t), 32'(int_sig_o), 32'(t >= 11));
        end
        wr(32'h0, 32'h4);
        check("presc_clr_int", 32'(int_sig_o), 32'd0);

        // W1C colliding with a match tick: hardware set wins
        wr(32'hC, 32'd0);
        wr(32'h8, 32'd3);
        wr(32'h4, 32'd0);
        wr(32'h0, 32'hB);
        idle(5);
        check("coll_ip_first", 32'(int_sig_o), 32'd1);
        wr(32'h0, 32'hF);
        check("coll_w1c_plain", 32'(int_sig_o), 32'd0);
        idle(1);
        wr(32'h0, 32'hF);
        check("coll_w1c_vs_tick", 32'(int_sig_o), 32'd1);
        rd_chk("coll_ctrl", 32'h0, 32'hF);
        wr(32'h0, 32'h4);
        check("coll_stop_int", 32'(int_sig_o), 32'd0);

        // COUNT write at a tick edge, then at a non-tick edge (pcnt restart), P=1
        wr(32'hC, 32'd1);
        wr(32'h8, 32'hFFFF);
        wr(32'h4, 32'd0);
        wr(32'h0, 32'h1);
        idle(3);
        wr(32'h4, 32'h10);
        rd_chk("cwr_tick", 32'h4, 32'h10);
        rd_chk("cwr_hold", 32'h4, 32'h10);
        wr(32'h4, 32'h20);
        rd_chk("cwr2_a", 32'h4, 32'h20);
        rd_chk("cwr2_pcnt_clr", 32'h4, 32'h20);
        rd_chk("cwr2_next", 32'h4, 32'h21);

        // Wrap without flag, IP with IE masked, then unmask
        wr(32'h0, 32'h4);
        wr(32'hC, 32'd0);
        wr(32'h8, 32'd1);
        wr(32'h4, 32'hFFFF_FFFE);
        wr(32'h0, 32'h1);
        rd_chk("wrap_t0", 32'h4, 32'hFFFF_FFFE);
        rd_chk("wrap_t1", 32'h4, 32'hFFFF_FFFF);
        rd_chk("wrap_t2", 32'h4, 32'h0);
        rd_chk("wrap_ctrl_noflag", 32'h0, 32'h1);
        rd_chk("wrap_ctrl_ip", 32'h0, 32'h5);
        check("wrap_masked_int", 32'(int_sig_o), 32'd0);
        wr(32'h0, 32'h3);
        check("wrap_unmask_int", 32'(int_sig_o), 32'd1);
        rd_chk("wrap_ctrl_after", 32'h0, 32'h7);

        // Async reset mid-access while counting with IP=1
        req_i  = 1'b1;
        we_i   = 1'b0;
        addr_i = 32'h4;
        @(posedge clk);
        #2;
        check("arst_pre_ack", 32'(ack_o), 32'd1);
        check("arst_pre_int", 32'(int_sig_o), 32'd1);
        rst = 1'b0;
        #1;
        check("arst_ack", 32'(ack_o), 32'd0);
        check("arst_int", 32'(int_sig_o), 32'd0);
        check("arst_data", data_o, 32'd0);
        req_i  = 1'b0;
        addr_i = '0;
        idle(2);
        rst = 1'b1;
        idle(3);
        rd_chk("arst_count", 32'h4, 32'd0);
        rd_chk("arst_ctrl", 32'h0, 32'd0);
        idle(3);
        rd_chk("arst_count_stopped", 32'h4, 32'd0);
        check("arst_int_after", 32'(int_sig_o), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
